// File: rtl/gt_rx_lane_checker_if.sv
// Lane bundle between a GTX RX user port and the lane checker:
// raw RX words in, aligned words, lock, packet pulses and counters out.
interface gt_rx_lane_checker_if #(
   parameter int BYTES = 4,
   parameter int CNT_W = 32
);
   localparam int DATA_W = 8 * BYTES;

   logic [DATA_W-1:0] gt_rx_data;
   logic [BYTES-1:0]  gt_rx_ctrl;
   logic [DATA_W-1:0] rx_data_align;
   logic [BYTES-1:0]  rx_ctrl_align;
   logic              locked;
   logic              pkt_ok;
   logic              pkt_err;
   logic [CNT_W-1:0]  packet_cnt_o;
   logic [CNT_W-1:0]  error_cnt_o;

   modport master (
      output gt_rx_data, gt_rx_ctrl,
      input  rx_data_align, rx_ctrl_align, locked, pkt_ok, pkt_err,
             packet_cnt_o, error_cnt_o
   );

   modport slave (
      input  gt_rx_data, gt_rx_ctrl,
      output rx_data_align, rx_ctrl_align, locked, pkt_ok, pkt_err,
             packet_cnt_o, error_cnt_o
   );
endinterface

// File: rtl/gt_rx_lane_checker.sv
// Receive lane checker: K28.5 byte alignment with lock hysteresis, SOP/payload/EOP
// framing, replicated-counter payload check and saturating good/bad packet counters.
module gt_rx_lane_checker #(
   parameter int BYTES    = 4,
   parameter int MAX_LEN  = 256,
   parameter int LOCK_CNT = 4,
   parameter int CNT_W    = 32
) (
   input logic                  rx_clk,
   input logic                  rst,
   gt_rx_lane_checker_if.slave  lane
);
   localparam int DATA_W = 8 * BYTES;
   localparam int K_W    = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_EOP} state_t;

   logic [DATA_W-1:0] prev_data_p0;
   logic [BYTES-1:0]  prev_ctrl_p0;
   logic [K_W-1:0]    k_reg;
   logic [K_W-1:0]    comma_k;
   logic              comma_hit;
   logic              offset_chg;
   logic [3:0]        lock_cnt;

   state_t            state;
   logic [15:0]       len_reg;
   logic [15:0]       wcnt;
   logic [7:0]        exp_byte;
   logic [15:0]       sop_len;
   logic [15:0]       len_word;
   logic              is_sop;
   logic              is_eop;
   logic              data_good;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic len_bad(input logic [15:0] l);
      return (l == 16'd0) || (32'(l) > 32'(MAX_LEN));
   endfunction

   // Lowest-indexed K28.5 in the incoming word wins.
   always_comb begin
      comma_hit = 1'b0;
      comma_k   = '0;
      for (int i = BYTES - 1; i >= 0; i--) begin
         if (lane.gt_rx_ctrl[i] && (lane.gt_rx_data[8*i +: 8] == 8'hBC)) begin
            comma_hit = 1'b1;
            comma_k   = K_W'(i);
         end
      end
   end

   assign offset_chg = comma_hit && (comma_k != k_reg);

   generate
      if (BYTES >= 4) begin : g_len_in_sop
         assign sop_len = lane.rx_data_align[31:16];
      end else begin : g_len_in_next
         assign sop_len = lane.rx_data_align[15:0];
      end
   endgenerate

   assign len_word  = lane.rx_data_align[15:0];
   assign is_sop    = (lane.rx_ctrl_align == BYTES'(1)) && (lane.rx_data_align[7:0] == 8'hFB);
   assign is_eop    = lane.rx_ctrl_align[0] && (lane.rx_data_align[7:0] == 8'hFD);
   assign data_good = (lane.rx_ctrl_align == '0) && (lane.rx_data_align == {BYTES{exp_byte}});

   // Stage p0: previous raw word, then aligned word selected from {cur, prev}.
   always_ff @(posedge rx_clk) begin
      if (rst) begin
         prev_data_p0       <= '0;
         prev_ctrl_p0       <= '0;
         lane.rx_data_align <= '0;
         lane.rx_ctrl_align <= '0;
         k_reg              <= '0;
         lock_cnt           <= '0;
         lane.locked        <= 1'b0;
      end else begin
         prev_data_p0       <= lane.gt_rx_data;
         prev_ctrl_p0       <= lane.gt_rx_ctrl;
         lane.rx_data_align <= DATA_W'({lane.gt_rx_data, prev_data_p0} >> {k_reg, 3'b000});
         lane.rx_ctrl_align <= BYTES'({lane.gt_rx_ctrl, prev_ctrl_p0} >> k_reg);
         if (offset_chg) begin
            k_reg    <= comma_k;
            lock_cnt <= 4'd1;
         end else if (comma_hit && (lock_cnt != 4'(LOCK_CNT))) begin
            lock_cnt <= lock_cnt + 4'd1;
         end
         // Lock follows the counter one cycle later so it lines up with the aligned data.
         lane.locked <= offset_chg ? 1'b0 : (lock_cnt == 4'(LOCK_CNT));
      end
   end

   // Framing FSM on the registered aligned word.
   always_ff @(posedge rx_clk) begin
      if (rst) begin
         state             <= S_IDLE;
         len_reg           <= '0;
         wcnt              <= '0;
         exp_byte          <= '0;
         lane.pkt_ok       <= 1'b0;
         lane.pkt_err      <= 1'b0;
         lane.packet_cnt_o <= '0;
         lane.error_cnt_o  <= '0;
      end else begin
         lane.pkt_ok  <= 1'b0;
         lane.pkt_err <= 1'b0;
         if (offset_chg && (state != S_IDLE)) begin
            lane.pkt_err     <= 1'b1;
            lane.error_cnt_o <= sat_inc(lane.error_cnt_o);
            state            <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (lane.locked && is_sop) begin
                     exp_byte <= 8'h00;
                     wcnt     <= '0;
                     if (BYTES == 2) begin
                        state <= S_LEN;
                     end else if (len_bad(sop_len)) begin
                        lane.pkt_err     <= 1'b1;
                        lane.error_cnt_o <= sat_inc(lane.error_cnt_o);
                     end else begin
                        len_reg <= sop_len;
                        state   <= S_DATA;
                     end
                  end
               end
               S_LEN: begin
                  if (len_bad(len_word)) begin
                     lane.pkt_err     <= 1'b1;
                     lane.error_cnt_o <= sat_inc(lane.error_cnt_o);
                     state            <= S_IDLE;
                  end else begin
                     len_reg <= len_word;
                     state   <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (!data_good) begin
                     lane.pkt_err     <= 1'b1;
                     lane.error_cnt_o <= sat_inc(lane.error_cnt_o);
                     state            <= S_IDLE;
                  end else if (wcnt == len_reg - 16'd1) begin
                     state <= S_EOP;
                  end else begin
                     wcnt     <= wcnt + 16'd1;
                     exp_byte <= exp_byte + 8'd1;
                  end
               end
               S_EOP: begin
                  if (is_eop) begin
                     lane.pkt_ok       <= 1'b1;
                     lane.packet_cnt_o <= sat_inc(lane.packet_cnt_o);
                  end else begin
                     lane.pkt_err     <= 1'b1;
                     lane.error_cnt_o <= sat_inc(lane.error_cnt_o);
                  end
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule
